spi_byte_master: RTL and testbench

- Byte-level SPI mode-0 master engine for the W25X-series serial flash.
- Sits directly below the flash command sequencers (ID read, data read, erase/program) and converts one byte per handshake into CS/SCLK/MOSI activity.
- Returns the byte sampled on MISO in the same transfer.
- Keeps chip select low across a multi-byte command until the upstream marks the final byte.

---
 rtl/spi_flash_pkg.sv | 31 +++
 rtl/spi_clk_gen.sv | 36 +++
 rtl/spi_byte_master.sv | 170 +++++++++++++++++
 tb/tb_spi_byte_master.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: engine states, W25X opcodes and default timing
// shared by the SPI flash byte engine and its command sequencers.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT_NEXT,
        HOLD,
        GAP
    } spi_state_t;

    localparam logic [7:0] CMD_MFR_DEV_ID = 8'h90;
    localparam logic [7:0] CMD_JEDEC_ID   = 8'h9F;
    localparam logic [7:0] CMD_READ       = 8'h03;
    localparam logic [7:0] CMD_WREN       = 8'h06;
    localparam logic [7:0] CMD_RDSR       = 8'h05;

    localparam int DEF_CLK_DIV  = 32;
    localparam int DEF_CS_SETUP = 4;
    localparam int DEF_CS_HOLD  = 4;
    localparam int DEF_CS_IDLE  = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SCLK half-period counter with rise/fall strobes;
// SCLK is forced low and the counter reloaded whenever en is low.
module spi_clk_gen #(
    parameter int CLK_DIV = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick,
    output logic sclk
);

    localparam int HW = $clog2(CLK_DIV + 1);
    localparam logic [HW-1:0] RELOAD = HW'(CLK_DIV - 1);

    logic [HW-1:0] cnt;
    logic          tick;

    assign tick      = en && (cnt == '0);
    assign rise_tick = tick && !sclk;
    assign fall_tick = tick && sclk;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= RELOAD;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt  <= RELOAD;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/spi_byte_master.sv
// spi_byte_master: SPI mode-0 byte engine below the W25X command sequencers.
// Define SPI_LSB_FIRST_EN to shift tx and rx LSB first (default MSB first).
module spi_byte_master
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD,
    parameter int CS_IDLE  = DEF_CS_IDLE
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       spi_cs_n,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam int TW = $clog2(max3(CS_SETUP, CS_HOLD, CS_IDLE) + 1);

    spi_state_t    state, state_n;
    logic [TW-1:0] cnt, cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    tx_sh, tx_sh_n;
    logic [7:0]    rx_sh, rx_sh_n;
    logic [7:0]    rx_data_n;
    logic          last, last_n;
    logic          cs_n_n, mosi_n, rx_valid_n;
    logic          accept, rise_tick, fall_tick;

`ifdef SPI_LSB_FIRST_EN
    function automatic logic out_bit(input logic [7:0] d);
        return d[0];
    endfunction
    function automatic logic [7:0] tx_next(input logic [7:0] d);
        return {1'b0, d[7:1]};
    endfunction
    function automatic logic [7:0] rx_next(input logic [7:0] d, input logic b);
        return {b, d[7:1]};
    endfunction
`else
    function automatic logic out_bit(input logic [7:0] d);
        return d[7];
    endfunction
    function automatic logic [7:0] tx_next(input logic [7:0] d);
        return {d[6:0], 1'b0};
    endfunction
    function automatic logic [7:0] rx_next(input logic [7:0] d, input logic b);
        return {d[6:0], b};
    endfunction
`endif

    assign accept = tx_valid && tx_ready;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .en        (state == SHIFT),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .sclk      (spi_clk)
    );

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_cnt_n  = bit_cnt;
        tx_sh_n    = tx_sh;
        rx_sh_n    = rx_sh;
        last_n     = last;
        cs_n_n     = spi_cs_n;
        mosi_n     = spi_mosi;
        rx_valid_n = 1'b0;
        rx_data_n  = rx_data;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = SETUP;
                    cnt_n     = TW'(CS_SETUP);
                    tx_sh_n   = tx_data;
                    last_n    = tx_last;
                    bit_cnt_n = 3'd7;
                    mosi_n    = out_bit(tx_data);
                end
            end
            SETUP: begin
                // CS drops one cycle after accept, then CS_SETUP cycles pass
                cs_n_n = 1'b0;
                if (cnt == '0) state_n = SHIFT;
                else           cnt_n   = cnt - 1'b1;
            end
            SHIFT: begin
                if (rise_tick) rx_sh_n = rx_next(rx_sh, spi_miso);
                if (fall_tick) begin
                    if (bit_cnt == 3'd0) begin
                        rx_valid_n = 1'b1;
                        rx_data_n  = rx_sh;
                        cnt_n      = TW'(CS_HOLD - 1);
                        state_n    = last ? HOLD : WAIT_NEXT;
                    end else begin
                        bit_cnt_n = bit_cnt - 3'd1;
                        tx_sh_n   = tx_next(tx_sh);
                        mosi_n    = out_bit(tx_sh_n);
                    end
                end
            end
            WAIT_NEXT: begin
                if (accept) begin
                    state_n   = SHIFT;
                    tx_sh_n   = tx_data;
                    last_n    = tx_last;
                    bit_cnt_n = 3'd7;
                    mosi_n    = out_bit(tx_data);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    cs_n_n  = 1'b1;
                    cnt_n   = TW'(CS_IDLE - 1);
                    state_n = GAP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            last     <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_cnt  <= bit_cnt_n;
            tx_sh    <= tx_sh_n;
            rx_sh    <= rx_sh_n;
            last     <= last_n;
            spi_cs_n <= cs_n_n;
            spi_mosi <= mosi_n;
            tx_ready <= (state_n == IDLE) || (state_n == WAIT_NEXT);
            rx_valid <= rx_valid_n;
            rx_data  <= rx_data_n;
            busy     <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: directed checks of the SPI byte engine against a
// W25X16 ID model (default timing) and a MISO loopback (CLK_DIV=1).
module tb_spi_byte_master;
    import spi_flash_pkg::*;

    localparam int D  = 32;
    localparam int SU = 4;
    localparam int HO = 4;
    localparam int ID = 8;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic       tx_valid = 1'b0, tx_last = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, rx_valid, busy, spi_cs_n, spi_clk, spi_mosi;
    logic       spi_miso = 1'b0;
    logic [7:0] rx_data;

    logic       f_tx_valid = 1'b0, f_tx_last = 1'b0;
    logic [7:0] f_tx_data = 8'h00;
    logic       f_tx_ready, f_rx_valid, f_busy, f_cs_n, f_clk, f_mosi;
    logic [7:0] f_rx_data;

    spi_byte_master #(.CLK_DIV(D), .CS_SETUP(SU), .CS_HOLD(HO), .CS_IDLE(ID)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_byte_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) u_fast (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .tx_valid(f_tx_valid), .tx_ready(f_tx_ready), .tx_data(f_tx_data), .tx_last(f_tx_last),
        .rx_valid(f_rx_valid), .rx_data(f_rx_data), .busy(f_busy),
        .spi_cs_n(f_cs_n), .spi_clk(f_clk), .spi_mosi(f_mosi), .spi_miso(f_mosi)
    );

    int n_chk = 0, n_err = 0, cyc = 0;
    always @(posedge sys_clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] wire8(input logic [7:0] b);
        logic [7:0] r;
        r = b;
`ifdef SPI_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = b[7 - i];
`endif
        return r;
    endfunction

    // bus monitors
    int rises = 0, cs_rises = 0, cs_rise_cyc = 0, cs_fall_cyc = 0;
    logic [7:0] mosi_sh = 8'h00;
    always @(posedge spi_clk) begin
        rises++;
        mosi_sh = {mosi_sh[6:0], spi_mosi};
    end
    always @(posedge spi_cs_n) begin
        cs_rises++;
        cs_rise_cyc = cyc;
    end
    always @(negedge spi_cs_n) cs_fall_cyc = cyc;

    int f_rise_last = 0, f_rise_prev = 0;
    logic [7:0] f_mosi_sh = 8'h00;
    always @(posedge f_clk) begin
        f_rise_prev = f_rise_last;
        f_rise_last = cyc;
        f_mosi_sh = {f_mosi_sh[6:0], f_mosi};
    end

    logic [7:0] rx_q[$];
    logic [7:0] f_rx_q[$];
    int rx_cyc_last = 0;
    always @(negedge sys_clk) begin
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            rx_cyc_last = cyc;
        end
        if (f_rx_valid) f_rx_q.push_back(f_rx_data);
    end

    // W25X16 manufacturer/device ID model: EF,14 after 90 + 24 address bits
    int fbit = 0;
    logic [7:0] fcmd = 8'h00;
    function automatic logic resp_bit(input int k);
        logic [15:0] id;
        id = 16'hEF14;
        if (fcmd == CMD_MFR_DEV_ID && k >= 33 && k <= 48) return id[48 - k];
        return 1'b0;
    endfunction
    always @(posedge spi_clk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            fbit = 0;
            fcmd = 8'h00;
        end else begin
            fbit++;
            if (fbit <= 8) fcmd = {fcmd[6:0], spi_mosi};
        end
    end
    always @(negedge spi_clk or negedge spi_cs_n)
        spi_miso = spi_cs_n ? 1'b0 : resp_bit(fbit + 1);

    int acc_cyc = 0;
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        @(negedge sys_clk);
        while (!tx_ready && n < 4000) begin
            @(negedge sys_clk);
            n++;
        end
        if (!tx_ready) begin
            chk("send_ready", tx_ready, 1);
            return;
        end
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        @(posedge sys_clk);
        #1;
        acc_cyc  = cyc;
        tx_valid = 1'b0;
    endtask

    task automatic send_f(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        @(negedge sys_clk);
        while (!f_tx_ready && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (!f_tx_ready) begin
            chk("send_f_ready", f_tx_ready, 1);
            return;
        end
        f_tx_valid = 1'b1;
        f_tx_data  = d;
        f_tx_last  = l;
        @(posedge sys_clk);
        #1;
        f_tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t;
        t = 0;
        while (rx_q.size() < n && t < budget) begin
            @(negedge sys_clk);
            t++;
        end
        if (rx_q.size() < n) chk("rx_count", rx_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        @(negedge sys_clk);
        while ((busy || !tx_ready) && t < budget) begin
            @(negedge sys_clk);
            t++;
        end
        chk("idle_reached", tx_ready, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, r0, r1, cs0, t;
        logic [7:0] e;

        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_clk", spi_clk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_ready", tx_ready, 0);
        chk("rst_rxv", rx_valid, 0);
        chk("rst_rxd", rx_data, 0);
        chk("rst_busy", busy, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // single byte A5, full frame timing
        rx_q.delete();
        r0 = rises;
        cs0 = cs_rises;
        send(wire8(8'hA5), 1'b1);
        a = acc_cyc;
        wait_rx(1, 2000);
        chk("t2_cs_fall", cs_fall_cyc - a, 1);
        chk("t2_latency", rx_cyc_last - a, SU + 16 * D + 1);
        chk("t2_mosi", mosi_sh, 8'hA5);
        chk("t2_rises", rises - r0, 8);
        if (rx_q.size() > 0) chk("t2_rx", rx_q[0], 8'h00);
        t = 0;
        while (cs_rises == cs0 && t < 200) begin
            @(negedge sys_clk);
            t++;
        end
        chk("t2_hold", cs_rise_cyc - rx_cyc_last, HO);
        t = 0;
        while (!tx_ready && t < 200) begin
            @(negedge sys_clk);
            t++;
        end
        chk("t2_gap", cyc - cs_rise_cyc, ID);

        // W25X16 manufacturer/device ID read
        rx_q.delete();
        r0 = rises;
        cs0 = cs_rises;
        send(wire8(8'h90), 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b1);
        wait_rx(6, 2000);
        chk("t1_cs_low", cs_rises - cs0, 0);
        chk("t1_rises", rises - r0, 48);
        if (rx_q.size() >= 6) begin
            chk("t1_mfr", rx_q[4], wire8(8'hEF));
            chk("t1_dev", rx_q[5], wire8(8'h14));
        end
        wait_idle(200);
        chk("t1_cs_end", cs_rises - cs0, 1);

        // upstream stall inside a frame
        rx_q.delete();
        r0 = rises;
        cs0 = cs_rises;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        wait_rx(2, 2000);
        r1 = rises;
        repeat (100) @(negedge sys_clk);
        chk("t3_stall_cs", spi_cs_n, 0);
        chk("t3_stall_clk", spi_clk, 0);
        chk("t3_stall_edges", rises - r1, 0);
        chk("t3_stall_busy", busy, 1);
        send(wire8(8'h33), 1'b1);
        wait_rx(3, 2000);
        chk("t3_mosi", mosi_sh, 8'h33);
        chk("t3_rises", rises - r0, 24);
        chk("t3_cs_low", cs_rises - cs0, 0);
        wait_idle(200);

        // reset after 3 SCLK rises
        rx_q.delete();
        r0 = rises;
        send(8'h5A, 1'b1);
        t = 0;
        while (rises - r0 < 3 && t < 1000) begin
            @(negedge sys_clk);
            t++;
        end
        chk("t5_rises", rises - r0, 3);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("t5_cs_n", spi_cs_n, 1);
        chk("t5_clk", spi_clk, 0);
        chk("t5_busy", busy, 0);
        chk("t5_rxv", rx_valid, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        chk("t5_no_rx", rx_q.size(), 0);
        r0 = rises;
        send(wire8(8'hC3), 1'b1);
        wait_rx(1, 2000);
        chk("t5_mosi", mosi_sh, 8'hC3);
        chk("t5_rises", rises - r0, 8);
        wait_idle(200);
        chk("t5_rx_once", rx_q.size(), 1);

        // CLK_DIV=1 loopback
        f_rx_q.delete();
        send_f(8'h00, 1'b0);
        send_f(8'hFF, 1'b0);
        send_f(8'h3C, 1'b1);
        t = 0;
        while (f_rx_q.size() < 3 && t < 200) begin
            @(negedge sys_clk);
            t++;
        end
        chk("t4_count", f_rx_q.size(), 3);
        if (f_rx_q.size() >= 3) begin
            chk("t4_rx0", f_rx_q[0], 8'h00);
            chk("t4_rx1", f_rx_q[1], 8'hFF);
            chk("t4_rx2", f_rx_q[2], 8'h3C);
        end
        chk("t4_period", f_rise_last - f_rise_prev, 2);

        // bit order on byte 01
        f_rx_q.delete();
        send_f(8'h01, 1'b1);
        t = 0;
        while (f_rx_q.size() < 1 && t < 200) begin
            @(negedge sys_clk);
            t++;
        end
        e = wire8(8'h01);
        chk("t6_first_mosi", f_mosi_sh[7], e[7]);
        chk("t6_wire", f_mosi_sh, e);
        if (f_rx_q.size() > 0) chk("t6_rx", f_rx_q[0], 8'h01);
        t = 0;
        while (f_busy && t < 50) begin
            @(negedge sys_clk);
            t++;
        end
        chk("t6_idle", f_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
